// File: rtl/wb_retire_buffer.sv
// wb_retire_buffer
//   Write-back retire buffer. It takes MA-stage results and selects either the load data or
//   the ALU result, based on the ctrl opcode. Pending register-file writes are held in a
//   DEPTH-entry FIFO. The buffer retires one write per cycle in which the shared RF write port
//   is granted. Stored entries can be looked up by register index, and the youngest match is
//   forwarded.
// Ports
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   ma_valid/ma_ready            MA request handshake; ma_ready = !full
//   ma_dest_idx, ma_wr_en        destination register and write enable of the request
//   ma_res, ma_data, ma_ctrl     ALU result, load data, opcode (selects which data is written)
//   rf_grant                     RF write port available this cycle
//   rf_req, rf_we                head pending / write strobe (rf_req & rf_grant)
//   rf_idx, rf_data              head entry, zero when empty
//   fwd_idx, fwd_hit, fwd_data   forwarding lookup over stored entries
//   count, full, empty           occupancy
module wb_retire_buffer #(
  parameter int unsigned    DATA_W   = 16,
  parameter int unsigned    IDX_W    = 5,
  parameter int unsigned    CTRL_W   = 5,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [CTRL_W-1:0] LOAD_OP  = 5'b01100,
  parameter logic [CTRL_W-1:0] LOADI_OP = 5'b01101
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ma_valid,
  output logic                       ma_ready,
  input  logic [IDX_W-1:0]           ma_dest_idx,
  input  logic                       ma_wr_en,
  input  logic [DATA_W-1:0]          ma_res,
  input  logic [DATA_W-1:0]          ma_data,
  input  logic [CTRL_W-1:0]          ma_ctrl,
  input  logic                       rf_grant,
  output logic                       rf_req,
  output logic                       rf_we,
  output logic [IDX_W-1:0]           rf_idx,
  output logic [DATA_W-1:0]          rf_data,
  input  logic [IDX_W-1:0]           fwd_idx,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [IDX_W-1:0]  idx_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic              push, pop;
  logic [DATA_W-1:0] wdata;
  logic [PtrW-1:0]   scan_ptr;

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign ma_ready = !full;
  assign rf_req   = !empty;
  assign rf_we    = rf_req & rf_grant;

  // Requests that do not write the RF, or that target r0, are accepted and dropped.
  assign push  = ma_valid & ma_ready & ma_wr_en & (ma_dest_idx != '0);
  assign pop   = rf_we;
  assign wdata = ((ma_ctrl == LOAD_OP) || (ma_ctrl == LOADI_OP)) ? ma_data : ma_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only observed while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[wr_ptr_q]  <= ma_dest_idx;
      data_mem[wr_ptr_q] <= wdata;
    end
  end

  always_comb begin
    rf_idx  = '0;
    rf_data = '0;
    if (!empty) begin
      rf_idx  = idx_mem[rd_ptr_q];
      rf_data = data_mem[rd_ptr_q];
    end
  end

  // Walk from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    scan_ptr = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_ptr = rd_ptr_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (fwd_idx != '0) && (idx_mem[scan_ptr] == fwd_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[scan_ptr];
      end
    end
  end

endmodule
